// File: rtl/red_seq_unit.sv
// Multi-cycle byte reducer: adds the four bytes of op_a/op_b through one shared
// 8-bit carry-lookahead adder, one pass per state, behind a start/busy/done handshake.

module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [8:0] sum
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pg
            assign g[gi]   = a[gi] & b[gi];
            assign p[gi]   = a[gi] ^ b[gi];
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Each carry is the flattened sum of generate terms gated by the propagate chain above them.
    always_comb begin
        logic prop;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            prop     = 1'b1;
            c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (prop & g[j]);
                prop     = prop & p[j];
            end
            c[i + 1] = c[i + 1] | (prop & cin);
        end
    end

    assign sum[8] = c[8];
endmodule

module red_seq_unit #(
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);
    typedef enum logic [2:0] {IDLE, ADD_HI, ADD_LO, SUM_LO, SUM_HI} state_t;

    state_t      state_q, state_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [8:0]  sum_hi_q, sum_hi_d;
    logic [8:0]  sum_lo_q, sum_lo_d;
    logic [7:0]  fin_lo_q, fin_lo_d;
    logic        c_q, c_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;

    logic [7:0]  add_a, add_b;
    logic        add_cin;
    logic [8:0]  add_sum;
    logic        part_bit8;
    logic [1:0]  ext_hi, ext_lo;
    logic [9:0]  fin;

    CLA_8bit u_cla (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Bit 8 of a byte-pair sum: true sign when signed, plain carry-out otherwise.
    assign part_bit8 = SIGN_EXT ? (add_a[7] ^ add_b[7] ^ add_sum[8]) : add_sum[8];
    assign ext_hi    = SIGN_EXT ? {2{sum_hi_q[8]}} : {1'b0, sum_hi_q[8]};
    assign ext_lo    = SIGN_EXT ? {2{sum_lo_q[8]}} : {1'b0, sum_lo_q[8]};
    assign fin       = {add_sum[1:0], fin_lo_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_hi_q <= '0;
            sum_lo_q <= '0;
            fin_lo_q <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_hi_q <= sum_hi_d;
            sum_lo_q <= sum_lo_d;
            fin_lo_q <= fin_lo_d;
            c_q      <= c_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_hi_d = sum_hi_q;
        sum_lo_d = sum_lo_q;
        fin_lo_d = fin_lo_q;
        c_d      = c_q;
        result_d = result_q;
        done_d   = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    state_d = ADD_HI;
                end
            end
            ADD_HI: begin
                add_a    = op_a_q[15:8];
                add_b    = op_b_q[15:8];
                sum_hi_d = {part_bit8, add_sum[7:0]};
                state_d  = ADD_LO;
            end
            ADD_LO: begin
                add_a    = op_a_q[7:0];
                add_b    = op_b_q[7:0];
                sum_lo_d = {part_bit8, add_sum[7:0]};
                state_d  = SUM_LO;
            end
            SUM_LO: begin
                add_a    = sum_hi_q[7:0];
                add_b    = sum_lo_q[7:0];
                fin_lo_d = add_sum[7:0];
                c_d      = add_sum[8];
                state_d  = SUM_HI;
            end
            SUM_HI: begin
                // Only the low two bits of this pass matter: the top of the 10-bit sum wraps mod 4.
                add_a    = {6'b0, ext_hi};
                add_b    = {6'b0, ext_lo};
                add_cin  = c_q;
                result_d = SIGN_EXT ? {{6{fin[9]}}, fin} : {6'b0, fin};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_red_seq_unit.sv
// Directed bench for red_seq_unit: a signed and an unsigned instance share stimulus,
// driven from a vector table plus hand-written back-to-back and reset sequences.

module tb_red_seq_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        busy_s, done_s, busy_u, done_u;
    logic [15:0] result_s, result_u;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_s;
        logic [15:0] exp_u;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    red_seq_unit #(.SIGN_EXT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy_s), .done(done_s), .result(result_s)
    );

    red_seq_unit #(.SIGN_EXT(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy_u), .done(done_u), .result(result_u)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is 1 time unit after a clock edge with the units idle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic [15:0] eu, input string nm);
        logic [15:0] prev_s;
        prev_s = result_s;
        op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            op_a = 16'($urandom); op_b = 16'($urandom);
            chk({nm, " busy"}, {15'b0, busy_s}, 16'd1);
            chk({nm, " done early"}, {15'b0, done_s}, 16'd0);
            if (k == 2) chk({nm, " result held"}, result_s, prev_s);
            tick();
        end
        chk({nm, " done"}, {15'b0, done_s}, 16'd1);
        chk({nm, " busy end"}, {15'b0, busy_s}, 16'd0);
        chk({nm, " done_u"}, {15'b0, done_u}, 16'd1);
        chk({nm, " result_s"}, result_s, es);
        chk({nm, " result_u"}, result_u, eu);
        $display("op %s a=%h b=%h result_s=%h result_u=%h", nm, a, b, result_s, result_u);
        tick();
        chk({nm, " done drop"}, {15'b0, done_s}, 16'd0);
        chk({nm, " result keep"}, result_s, es);
    endtask

    initial begin
        vecs[0] = '{16'h0102, 16'h0304, 16'h000A, 16'h000A};
        vecs[1] = '{16'h7F7F, 16'h7F7F, 16'h01FC, 16'h01FC};
        vecs[2] = '{16'h8080, 16'h8080, 16'hFE00, 16'h0200};
        vecs[3] = '{16'hFF01, 16'h0000, 16'h0000, 16'h0100};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFC, 16'h03FC};
        vecs[5] = '{16'h1234, 16'h5678, 16'h0114, 16'h0114};
        vecs[6] = '{16'h80FF, 16'h0101, 16'hFF81, 16'h0181};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        tick();
        chk("reset busy", {15'b0, busy_s}, 16'd0);
        chk("reset done", {15'b0, done_s}, 16'd0);
        chk("reset result", result_s, 16'h0000);
        #3 rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_s, vecs[i].exp_u, $sformatf("vec%0d", i));

        // start held high: a new op every 5 edges, operands scrambled while busy.
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = vecs[i + 4].a; op_b = vecs[i + 4].b;
            tick();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("held%0d busy", i), {15'b0, busy_s}, 16'd1);
                chk($sformatf("held%0d no done", i), {15'b0, done_s}, 16'd0);
                op_a = 16'($urandom); op_b = 16'($urandom);
                tick();
            end
            chk($sformatf("held%0d done", i), {15'b0, done_s}, 16'd1);
            chk($sformatf("held%0d result_s", i), result_s, vecs[i + 4].exp_s);
            chk($sformatf("held%0d result_u", i), result_u, vecs[i + 4].exp_u);
            $display("held op %0d result_s=%h result_u=%h", i, result_s, result_u);
        end
        start = 1'b0;
        tick();
        chk("held done drop", {15'b0, done_s}, 16'd0);
        chk("held idle", {15'b0, busy_s}, 16'd0);

        // Reset during SUM_LO: immediate clear, no done pulse afterwards.
        run_op(16'h0102, 16'h0304, 16'h000A, 16'h000A, "pre_rst");
        op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst busy", {15'b0, busy_s}, 16'd0);
        chk("rst done", {15'b0, done_s}, 16'd0);
        chk("rst result", result_s, 16'h0000);
        #3 rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("post rst no done", {15'b0, done_s}, 16'd0);
            tick();
        end
        $display("reset abort result_s=%h", result_s);
        run_op(16'h0001, 16'h0001, 16'h0002, 16'h0002, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
